// File: rtl/pingpang_pkg.sv
// Shared types and defaults for the ping-pong bank controller.
package pingpang_pkg;

    typedef enum logic [1:0] {FREE, FILL, FULL, READ} bank_st_e;
    typedef enum logic [1:0] {INIT, WRITE, STALL} wr_st_e;

    localparam logic [15:0] HEADER_DEF       = 16'h9999;
    localparam int unsigned FRAME_LEN_DEF    = 390;
    localparam int unsigned RD_PER_FRAME_DEF = 782;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pingpang_rd_tracker.sv
// Read-side bookkeeping: strobe counter, post-release IRQ gap, optional idle watchdog.
// The watchdog exists only when PP_TIMEOUT_EN is defined; otherwise timeout_cnt is 0.
module pingpang_rd_tracker
    import pingpang_pkg::*;
#(
    parameter int unsigned RD_PER_FRAME = RD_PER_FRAME_DEF,
    parameter int unsigned IRQ_GAP      = 12,
    parameter int unsigned TIMEOUT      = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_read,
    input  logic       arm_rd_pulse,
    output logic       release_o,
    output logic       gap_ok,
    output logic [7:0] timeout_cnt
);
    localparam int unsigned RCW = $clog2(RD_PER_FRAME + 1);
    localparam int unsigned GW  = $clog2(IRQ_GAP + 1);

    if (TIMEOUT == 0 || IRQ_GAP == 0) begin : g_param_chk
        $fatal(1, "pingpang_rd_tracker: TIMEOUT and IRQ_GAP must be nonzero");
    end

    logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           done_hit;
    logic           to_hit;

`ifdef PP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_q, idle_d;
    logic [7:0]    to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        gap_d    = gap_q;
        done_hit = 1'b0;
        to_hit   = 1'b0;
`ifdef PP_TIMEOUT_EN
        idle_d   = idle_q;
        to_cnt_d = to_cnt_q;
        // Any strobe restarts the idle window; only READ cycles count.
        if (in_read) begin
            if (arm_rd_pulse)                  idle_d = '0;
            else if (idle_q == TW'(TIMEOUT-1)) to_hit = 1'b1;
            else                               idle_d = idle_q + 1'b1;
        end
        if (to_hit && to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
`endif
        if (in_read && arm_rd_pulse) begin
            if (rd_cnt_q == RCW'(RD_PER_FRAME-1)) done_hit = 1'b1;
            else                                  rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (done_hit || to_hit) begin
            rd_cnt_d = '0;
            gap_d    = GW'(IRQ_GAP-1);
`ifdef PP_TIMEOUT_EN
            idle_d   = '0;
`endif
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            gap_q    <= '0;
`ifdef PP_TIMEOUT_EN
            idle_q   <= '0;
            to_cnt_q <= '0;
`endif
        end else begin
            rd_cnt_q <= rd_cnt_d;
            gap_q    <= gap_d;
`ifdef PP_TIMEOUT_EN
            idle_q   <= idle_d;
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

    assign release_o = done_hit | to_hit;
    assign gap_ok    = (gap_q == '0);
`ifdef PP_TIMEOUT_EN
    assign timeout_cnt = to_cnt_q;
`else
    assign timeout_cnt = 8'd0;
`endif

endmodule

// File: rtl/pingpang_bank_ctrl.sv
// Two-bank ping-pong scheduler: owns bank write ports, bank ownership and ARM handoff.
// Optional read watchdog enabled by defining PP_TIMEOUT_EN.
module pingpang_bank_ctrl
    import pingpang_pkg::*;
#(
    parameter int unsigned DW           = 16,
    parameter int unsigned AW           = 9,
    parameter int unsigned FRAME_LEN    = FRAME_LEN_DEF,
    parameter logic [DW-1:0] HEADER     = DW'(HEADER_DEF),
    parameter int unsigned RD_PER_FRAME = RD_PER_FRAME_DEF,
    parameter int unsigned IRQ_GAP      = 12,
    parameter int unsigned TIMEOUT      = 50000
) (
    input  logic          clk_50m,
    input  logic          rst,
    input  logic          din_flag,
    input  logic [DW-1:0] din,
    input  logic          arm_rd_pulse,
    output logic          bank0_wr_en,
    output logic [AW-1:0] bank0_wr_addr,
    output logic [DW-1:0] bank0_wr_data,
    output logic          bank1_wr_en,
    output logic [AW-1:0] bank1_wr_addr,
    output logic [DW-1:0] bank1_wr_data,
    output logic          rd_sel,
    output logic          fpga_to_arm,
    output logic [15:0]   drop_cnt,
    output logic [7:0]    timeout_cnt
);
    bank_st_e      bank_q [2];
    bank_st_e      bank_d [2];
    wr_st_e        wr_q, wr_d;
    logic          wb_q, wb_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_sel_q, rd_sel_d;
    logic          irq_q, irq_d;
    logic [15:0]   drop_q, drop_d;
    logic          wr_en_q [2];
    logic          wr_en_d [2];
    logic [AW-1:0] wr_addr_q [2];
    logic [AW-1:0] wr_addr_d [2];
    logic [DW-1:0] wr_data_q [2];
    logic [DW-1:0] wr_data_d [2];

    logic in_read, rb, rel, gap_ok, grant, gb, ob, ob_free;

    assign in_read = (bank_q[0] == READ) || (bank_q[1] == READ);
    assign rb      = (bank_q[1] == READ);
    assign grant   = !in_read && gap_ok && (bank_q[0] == FULL || bank_q[1] == FULL);
    assign gb      = (bank_q[0] != FULL);
    assign ob      = ~wb_q;
    // A bank released this cycle counts as free for the writer.
    assign ob_free = (bank_q[ob] == FREE) || (rel && rb == ob);

    pingpang_rd_tracker #(
        .RD_PER_FRAME(RD_PER_FRAME),
        .IRQ_GAP     (IRQ_GAP),
        .TIMEOUT     (TIMEOUT)
    ) u_rd_tracker (
        .clk         (clk_50m),
        .rst         (rst),
        .in_read     (in_read),
        .arm_rd_pulse(arm_rd_pulse),
        .release_o   (rel),
        .gap_ok      (gap_ok),
        .timeout_cnt (timeout_cnt)
    );

    always_comb begin
        bank_d    = bank_q;
        wr_d      = wr_q;
        wb_d      = wb_q;
        addr_d    = addr_q;
        rd_sel_d  = rd_sel_q;
        irq_d     = irq_q;
        drop_d    = drop_q;
        wr_en_d   = '{1'b0, 1'b0};
        wr_addr_d = '{'0, '0};
        wr_data_d = '{'0, '0};

        case (wr_q)
            INIT: begin
                wr_en_d   = '{1'b1, 1'b1};
                wr_data_d = '{HEADER, HEADER};
                bank_d[0] = FILL;
                wb_d      = 1'b0;
                addr_d    = AW'(1);
                wr_d      = WRITE;
            end
            WRITE: begin
                if (din_flag) begin
                    wr_en_d[wb_q]   = 1'b1;
                    wr_addr_d[wb_q] = addr_q;
                    wr_data_d[wb_q] = din;
                    if (addr_q == AW'(FRAME_LEN)) begin
                        bank_d[wb_q] = FULL;
                        if (ob_free) begin
                            bank_d[ob] = FILL;
                            wb_d       = ob;
                            addr_d     = AW'(1);
                        end else begin
                            wr_d = STALL;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            STALL: begin
                if (din_flag) drop_d = sat_inc16(drop_q);
                if (rel) begin
                    bank_d[rb] = FILL;
                    wb_d       = rb;
                    addr_d     = AW'(1);
                    wr_d       = WRITE;
                end
            end
            default: wr_d = INIT;
        endcase

        // Released bank gets its header back so it is ready for the next frame.
        if (rel) begin
            wr_en_d[rb]   = 1'b1;
            wr_addr_d[rb] = '0;
            wr_data_d[rb] = HEADER;
            if (bank_d[rb] == READ) bank_d[rb] = FREE;
            irq_d = 1'b0;
        end
        if (grant) begin
            bank_d[gb] = READ;
            rd_sel_d   = gb;
            irq_d      = 1'b1;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            bank_q    <= '{FREE, FREE};
            wr_q      <= INIT;
            wb_q      <= 1'b0;
            addr_q    <= '0;
            rd_sel_q  <= 1'b0;
            irq_q     <= 1'b0;
            drop_q    <= '0;
            wr_en_q   <= '{1'b0, 1'b0};
            wr_addr_q <= '{'0, '0};
            wr_data_q <= '{'0, '0};
        end else begin
            bank_q    <= bank_d;
            wr_q      <= wr_d;
            wb_q      <= wb_d;
            addr_q    <= addr_d;
            rd_sel_q  <= rd_sel_d;
            irq_q     <= irq_d;
            drop_q    <= drop_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bank0_wr_en   = wr_en_q[0];
    assign bank0_wr_addr = wr_addr_q[0];
    assign bank0_wr_data = wr_data_q[0];
    assign bank1_wr_en   = wr_en_q[1];
    assign bank1_wr_addr = wr_addr_q[1];
    assign bank1_wr_data = wr_data_q[1];
    assign rd_sel        = rd_sel_q;
    assign fpga_to_arm   = irq_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_pingpang_bank_ctrl.sv
// Randomized bench for pingpang_bank_ctrl against a frame/ownership reference model.
module tb_pingpang_bank_ctrl;
    localparam int FRAME_LEN    = 390;
    localparam int RD_PER_FRAME = 782;
    localparam int IRQ_GAP      = 12;
    localparam int TO           = 100;
    localparam logic [15:0] HEADER = 16'h9999;
    localparam int OWN_FREE = 0, OWN_FILL = 1, OWN_FULL = 2, OWN_READ = 3;

    logic        clk_50m = 1'b0;
    logic        rst = 1'b1, din_flag = 1'b0, arm_rd_pulse = 1'b0;
    logic [15:0] din = '0;
    logic        bank0_wr_en, bank1_wr_en, rd_sel, fpga_to_arm;
    logic [8:0]  bank0_wr_addr, bank1_wr_addr;
    logic [15:0] bank0_wr_data, bank1_wr_data, drop_cnt;
    logic [7:0]  timeout_cnt;

    int n_chk = 0, n_fail = 0;

    // Reference model state
    int          m_own [2];
    bit          m_init, m_stall, m_irq;
    int          m_wb, m_addr, m_rdcnt, m_idle, m_rdsel, m_drop, m_tocnt;
    int          m_cyc, m_rel_cyc;
    bit          m_en [2];
    int          m_ad [2];
    logic [15:0] m_dt [2];

    always #10 clk_50m = ~clk_50m;

    pingpang_bank_ctrl #(.TIMEOUT(TO)) dut (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .din_flag     (din_flag),
        .din          (din),
        .arm_rd_pulse (arm_rd_pulse),
        .bank0_wr_en  (bank0_wr_en),
        .bank0_wr_addr(bank0_wr_addr),
        .bank0_wr_data(bank0_wr_data),
        .bank1_wr_en  (bank1_wr_en),
        .bank1_wr_addr(bank1_wr_addr),
        .bank1_wr_data(bank1_wr_data),
        .rd_sel       (rd_sel),
        .fpga_to_arm  (fpga_to_arm),
        .drop_cnt     (drop_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // One clock of the reference: reads, gap rule, writer, release, grant.
    task automatic model_step(input bit r, input bit f, input logic [15:0] d, input bit p);
        bit reading, rel, grant;
        int rb, gb, ob;
        m_en = '{0, 0};
        m_ad = '{0, 0};
        m_dt = '{16'h0, 16'h0};
        m_cyc++;
        if (r) begin
            m_own = '{OWN_FREE, OWN_FREE};
            m_init = 1; m_stall = 0; m_irq = 0;
            m_wb = 0; m_addr = 0; m_rdcnt = 0; m_idle = 0; m_rdsel = 0;
            m_drop = 0; m_tocnt = 0; m_rel_cyc = m_cyc - IRQ_GAP;
            return;
        end
        reading = (m_own[0] == OWN_READ) || (m_own[1] == OWN_READ);
        rb  = (m_own[1] == OWN_READ) ? 1 : 0;
        rel = 0;
        if (reading) begin
            if (p) begin
                m_rdcnt++; m_idle = 0;
                if (m_rdcnt == RD_PER_FRAME) rel = 1;
            end else begin
                m_idle++;
`ifdef PP_TIMEOUT_EN
                if (m_idle == TO) begin
                    rel = 1;
                    if (m_tocnt < 255) m_tocnt++;
                end
`endif
            end
        end
        if (rel) begin m_rdcnt = 0; m_idle = 0; end
        grant = !reading && (m_cyc - m_rel_cyc >= IRQ_GAP) &&
                (m_own[0] == OWN_FULL || m_own[1] == OWN_FULL);
        gb = (m_own[0] == OWN_FULL) ? 0 : 1;

        if (m_init) begin
            m_en = '{1, 1};
            m_dt = '{HEADER, HEADER};
            m_own[0] = OWN_FILL; m_wb = 0; m_addr = 1; m_init = 0;
        end else if (m_stall) begin
            if (f && m_drop < 16'hFFFF) m_drop++;
            if (rel) begin
                m_own[rb] = OWN_FILL; m_wb = rb; m_addr = 1; m_stall = 0;
            end
        end else if (f) begin
            m_en[m_wb] = 1; m_ad[m_wb] = m_addr; m_dt[m_wb] = d;
            if (m_addr == FRAME_LEN) begin
                m_own[m_wb] = OWN_FULL;
                ob = 1 - m_wb;
                if (m_own[ob] == OWN_FREE || (rel && rb == ob)) begin
                    m_own[ob] = OWN_FILL; m_wb = ob; m_addr = 1;
                end else begin
                    m_stall = 1;
                end
            end else begin
                m_addr++;
            end
        end
        if (rel) begin
            m_en[rb] = 1; m_ad[rb] = 0; m_dt[rb] = HEADER;
            if (m_own[rb] == OWN_READ) m_own[rb] = OWN_FREE;
            m_irq = 0; m_rel_cyc = m_cyc;
        end
        if (grant) begin
            m_own[gb] = OWN_READ; m_rdsel = gb; m_irq = 1;
        end
    endtask

    task automatic compare_all();
        chk("irq", fpga_to_arm, m_irq);
        chk("rd_sel", rd_sel, m_rdsel);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("timeout_cnt", timeout_cnt, m_tocnt);
        chk("wr_en0", bank0_wr_en, m_en[0]);
        chk("wr_en1", bank1_wr_en, m_en[1]);
        if (m_en[0]) begin
            chk("wr_addr0", bank0_wr_addr, m_ad[0]);
            chk("wr_data0", bank0_wr_data, m_dt[0]);
        end
        if (m_en[1]) begin
            chk("wr_addr1", bank1_wr_addr, m_ad[1]);
            chk("wr_data1", bank1_wr_data, m_dt[1]);
        end
    endtask

    // Drive at negedge, step the model on posedge, compare on the next negedge.
    task automatic cyc(input bit r, input bit f, input bit p);
        logic [15:0] d;
        d = 16'($urandom);
        rst = r; din_flag = f; din = d; arm_rd_pulse = p;
        @(posedge clk_50m);
        model_step(r, f, d, p);
        @(negedge clk_50m);
        compare_all();
    endtask

    task automatic run_rand(input int n, input int pf, input int pp);
        for (int i = 0; i < n; i++)
            cyc(0, $urandom_range(99) < pf, $urandom_range(99) < pp);
    endtask

    initial begin
        m_cyc = 0;
        @(negedge clk_50m);
        repeat (3) cyc(1, 0, 0);
        chk("rst_irq", fpga_to_arm, 1'b0);
        chk("rst_drop", drop_cnt, 16'd0);
        chk("rst_en0", bank0_wr_en, 1'b0);

        // INIT: header into both banks together
        cyc(0, 0, 0);
        chk("init_hdr0", {bank0_wr_en, bank0_wr_addr, bank0_wr_data}, {1'b1, 9'd0, HEADER});
        chk("init_hdr1", {bank1_wr_en, bank1_wr_addr, bank1_wr_data}, {1'b1, 9'd0, HEADER});

        // Fill both banks with the ARM idle, then five extra samples
        for (int i = 0; i < 2 * FRAME_LEN + 5; i++) cyc(0, 1, 0);
`ifndef PP_TIMEOUT_EN
        chk("drop5", drop_cnt, 16'd5);
        chk("irq_bank0", {fpga_to_arm, rd_sel}, 2'b10);
        for (int i = 0; i < RD_PER_FRAME; i++) cyc(0, 0, 1);
        chk("rel_irq", fpga_to_arm, 1'b0);
        cyc(0, 1, 0);
        chk("resume", {bank0_wr_en, bank0_wr_addr}, {1'b1, 9'd1});
`else
        repeat (2 * TO + 20) cyc(0, 0, 0);
        chk("timeout_seen", timeout_cnt != 8'd0, 1'b1);
`endif

        run_rand(2200, 50, 0);
        run_rand(4000, 33, 75);
        run_rand(1500, 60, 95);

        // Reset mid-frame, then restart cleanly
        repeat (2) cyc(1, 0, 0);
        for (int i = 0; i < 201; i++) cyc(0, 1, 0);
        repeat (2) cyc(1, 1, 1);
        chk("mid_rst_drop", drop_cnt, 16'd0);
        chk("mid_rst_irq", fpga_to_arm, 1'b0);
        cyc(0, 0, 0);
        chk("mid_rst_hdr", {bank0_wr_en, bank1_wr_en, bank0_wr_data}, {2'b11, HEADER});
        run_rand(3000, 50, 60);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pingpang_bank_ctrl.md
Name: pingpang_bank_ctrl

Overview:
Single-clock scheduler for the two-bank ping-pong sample buffer between the acquisition datapath and the ARM read bus. Owns both bank write ports (header plus sample addresses), tracks each bank's ownership (FREE/FILL/FULL/READ), and hands full banks to the ARM. Drives the read-bank select and the fpga_to_arm interrupt, and accounts for dropped samples when the ARM falls behind.

Parameters:
DW, 16, sample and RAM data width
AW, 9, bank address width
FRAME_LEN, 390, samples per frame, written at addresses 1..FRAME_LEN
HEADER, 16'h9999, marker word written at address 0 of each bank
RD_PER_FRAME, 782, ARM read strobes that complete one bank (2 per word, including the header)
IRQ_GAP, 12, minimum cycles fpga_to_arm stays low between two banks
TIMEOUT, 50000, idle cycles in READ before a forced release

Ports:
clk_50m  in  1  system clock
rst  in  1  synchronous reset, active-high
din_flag  in  1  sample valid strobe, one cycle per sample
din  in  DW  sample data
arm_rd_pulse  in  1  one-cycle pulse per completed ARM read (edge-detected upstream)
bank0_wr_en / bank1_wr_en  out  1  bank write enables
bank0_wr_addr / bank1_wr_addr  out  AW  bank write addresses
bank0_wr_data / bank1_wr_data  out  DW  bank write data
rd_sel  out  1  bank currently owned by the ARM (0/1)
fpga_to_arm  out  1  interrupt: a bank is ready or being read
drop_cnt  out  16  dropped samples, saturating
timeout_cnt  out  8  forced releases, saturating

Behaviour:
- Reset (rst high at a clk_50m edge): both banks FREE; all outputs 0; internal counters 0. Reset mid-frame abandons the frame; no partial bank is ever presented.
- INIT (first cycle after reset): both banks written with HEADER at address 0 in the same cycle. Writer targets bank0 (FILL), next address 1.
- Writing: each din_flag writes din to the target bank at addresses 1..FRAME_LEN, with wr_en registered (1-cycle latency from din_flag). The write at FRAME_LEN marks the bank FULL in that cycle.
- Bank switch: the writer switches to the other bank if it is FREE, in the same cycle, with no sample lost. Otherwise the writer enters STALL.
- STALL: din_flag samples are discarded and drop_cnt is incremented (saturating at 16'hFFFF). The writer resumes at address 1 of the first bank released; samples arriving in the release cycle are still dropped.
- Read grant: when a bank is FULL, no bank is in READ, and the gap counter has expired, the bank goes to READ. rd_sel is set to it and fpga_to_arm rises on the next edge.
- Read accounting: arm_rd_pulse pulses are counted only in READ. At pulse number RD_PER_FRAME the bank becomes FREE, fpga_to_arm drops, and its address 0 is rewritten with HEADER in the release cycle. The IRQ_GAP counter then starts.
- Simultaneous events: a release and the writer completing the other bank in the same cycle lets the writer take the freed bank immediately. The newly FULL bank is granted after IRQ_GAP.
- Stray pulses: arm_rd_pulse outside READ is ignored.
- rd_sel holds its last value while idle.

Optional Feature:
PP_TIMEOUT_EN:
- Defined: in READ, TIMEOUT consecutive cycles without arm_rd_pulse force the release path (identical to a normal release) and increment timeout_cnt (saturating). Any pulse restarts the count.
- Undefined: no watchdog; timeout_cnt is tied to 0; READ lasts until RD_PER_FRAME pulses arrive.

Decomposition:
- Package pingpang_pkg: bank-state enum (FREE, FILL, FULL, READ), writer-state enum (INIT, WRITE, STALL), default constants for HEADER, FRAME_LEN, RD_PER_FRAME.
- One sub-module, pingpang_rd_tracker: read-strobe counter, IRQ_GAP counter, and optional watchdog, with a release-pulse output.

Test Plan:
- Reset release -> both banks get addr0=16'h9999 in cycle 1; writer on bank0; fpga_to_arm=0.
- 390 din_flag pulses -> bank0 FULL, writer on bank1 addr 1, rd_sel=0, fpga_to_arm=1 one cycle later.
- 782 arm_rd_pulse in READ -> bank0 FREE and header rewritten, fpga_to_arm low for ≥12 cycles, then bank1 granted if FULL.
- ARM idle while both banks fill, then 5 extra samples -> drop_cnt=5; on release the writer resumes at addr 1 of bank0.
- PP_TIMEOUT_EN with TIMEOUT=100 and no reads -> release at cycle 100 of READ, timeout_cnt=1.
- rst asserted mid-frame at sample 200 -> all banks FREE, counters 0, INIT header writes repeated.
